rx_frame_sequencer: RTL
=======================

Name: rx_frame_sequencer

Overview:
Sequences the UART receive FIFO. It pops bytes from the RX FIFO and parses framed host commands of the form [opcode, length, payload×length, checksum]. Each command header is presented to the uTPU control path, and the payload is streamed byte-by-byte to the loader with valid/ready handshakes. Framing errors and stalled frames are reported, and the parser resynchronises on the next byte.

Parameters:
MAX_LEN, 16, largest legal payload length in bytes; length byte > MAX_LEN is an error
TIMEOUT, 1024, cycles with no byte available mid-frame before the frame is aborted
DATA_WIDTH, 8, byte width; fixed at 8, present only for FIFO port matching

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fifo_empty  in  1  RX FIFO empty flag
fifo_re  out  1  RX FIFO read enable
fifo_rdata  in  8  RX FIFO registered read data; valid the cycle after a read, stable until the next read
cmd_valid  out  1  command header valid
cmd_ready  in  1  command header accepted
cmd_op  out  8  opcode
cmd_len  out  8  payload length
pay_valid  out  1  payload byte valid
pay_ready  in  1  payload byte accepted
pay_data  out  8  payload byte
pay_last  out  1  marks the final payload byte
frm_done  out  1  one-cycle pulse: frame complete, checksum good
err_valid  out  1  one-cycle pulse: frame error
err_code  out  2  0 bad opcode, 1 bad length, 2 checksum mismatch, 3 timeout; valid with err_valid
busy  out  1  high in every state except S_OP

Behaviour:
- Reset (async, rst_n=0): state S_OP; byte_vld=0; all outputs 0 (fifo_re, cmd_valid, pay_valid, pay_last, frm_done, err_valid, err_code, busy).
- Mid-frame reset discards the partial frame. FIFO contents are not flushed.
- Fetch stage: fifo_rdata is the holding register.
  - fifo_re = !fifo_empty && (!byte_vld || byte_take).
  - Next-cycle byte_vld = fifo_re ? 1 : (byte_take ? 0 : byte_vld).
  - Sustains 1 byte/cycle. fifo_re is never asserted while fifo_empty=1.
- byte_take is asserted only by the FSM state consuming the current byte.
- Running checksum: csum = XOR of opcode, length and all payload bytes. It is cleared on entry to S_OP.
- FSM:
  - S_OP: take byte when byte_vld.
    - Legal opcode (package list): latch cmd_op, go S_LEN.
    - Otherwise: err code 0, stay S_OP (byte dropped).
  - S_LEN: take byte.
    - Length > MAX_LEN: err code 1, go S_OP.
    - Otherwise: latch cmd_len, go S_CMD.
  - S_CMD: cmd_valid=1 with cmd_op/cmd_len held stable until cmd_ready. No byte taken. Then go S_PAY if len>0, else S_CSUM.
  - S_PAY:
    - pay_valid=byte_vld; pay_data=fifo_rdata.
    - byte_take = pay_valid && pay_ready.
    - Remaining-count decrements on each take.
    - pay_last=1 when remaining==1.
    - On the last take, go S_CSUM.
  - S_CSUM: take byte.
    - Equal to csum: frm_done pulse.
    - Not equal: err code 2.
    - Either way go S_OP.
- Latency:
  - cmd_valid rises 1 cycle after the length byte is taken.
  - frm_done/err_valid assert the cycle after the deciding byte is taken.
- Timeout counter:
  - Cleared in S_OP, in S_CMD, and on every byte_take.
  - Increments in S_LEN/S_PAY/S_CSUM only while byte_vld=0.
  - Reaching TIMEOUT-1: err code 3, go S_OP.
  - A downstream stall (byte_vld=1, pay_ready=0) does not count.
- An error detected in S_CSUM after the payload was forwarded is signalled by err_valid only; downstream discards the payload.
- frm_done and err_valid are mutually exclusive.

Decomposition:
- Package rx_frame_pkg:
  - opcode constants OP_LOAD_W=8'h01, OP_LOAD_A=8'h02, OP_RUN=8'h03, OP_READ=8'h04, and is_legal_op function;
  - err_code enum;
  - state enum S_OP, S_LEN, S_CMD, S_PAY, S_CSUM.
- No sub-module. The fetch stage, FSM and timeout counter live in one module.

Test Plan:
- Good frame: push 01 02 AA 55 FC, cmd_ready=pay_ready=1 → cmd (01,02) once; pay AA then 55 with pay_last on 55; frm_done one pulse; no err.
- Zero-length frame: push 03 00 03 → cmd (03,00); no pay_valid; frm_done.
- Bad opcode then resync: push 7F 03 00 03 → err_code 0 once; then cmd (03,00) and frm_done.
- Bad length: push 01 11 with MAX_LEN=16 → err_code 1, no cmd_valid. Checksum mismatch: push 01 01 AA 00 → pay AA, err_code 2, no frm_done.
- Backpressure: good frame with cmd_ready held low 5 cycles and pay_ready toggling → outputs stable while stalled; byte order intact; no timeout error.
- Timeout and reset: push 01 02 AA only, TIMEOUT=32 → err_code 3 at 32 idle cycles, busy=0 after. Separately, assert rst_n low during S_PAY → all outputs 0 immediately, state S_OP.

Source files
------------

// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// rx_frame_pkg : opcodes, error codes and parser states for rx_frame_sequencer
// Revision: 1.0
// ============================================================================
package rx_frame_pkg;

  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_A = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_READ   = 8'h04;

  typedef enum logic [1:0] {
    ERR_BAD_OP  = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_LEN  = 3'd1,
    S_CMD  = 3'd2,
    S_PAY  = 3'd3,
    S_CSUM = 3'd4
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_LOAD_W) || (op == OP_LOAD_A) || (op == OP_RUN) || (op == OP_READ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// rx_frame_sequencer : parses [op, len, payload, csum] frames from the RX FIFO
// Revision: 1.0
// ============================================================================
module rx_frame_sequencer
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT    = 1024,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_op,
  output logic [7:0]            cmd_len,
  output logic                  pay_valid,
  input  logic                  pay_ready,
  output logic [DATA_WIDTH-1:0] pay_data,
  output logic                  pay_last,
  output logic                  frm_done,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int              TMO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  state_e                state_q, state_d;
  logic                  byte_vld_q, byte_vld_d;
  logic                  run_q;
  logic [7:0]            cmd_op_q, cmd_op_d;
  logic [7:0]            cmd_len_q, cmd_len_d;
  logic [7:0]            rem_q, rem_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  frm_done_q, frm_done_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  busy_q, busy_d;
  logic                  byte_take;
  logic                  tmo_active;

  always_comb begin
    state_d     = state_q;
    byte_take   = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_len_d   = cmd_len_q;
    rem_d       = rem_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    frm_done_d  = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    tmo_active  = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CSUM);

    case (state_q)
      S_OP: begin
        csum_d = '0;
        tmo_d  = '0;
        if (byte_vld_q) begin
          byte_take = 1'b1;
          if (is_legal_op(fifo_rdata)) begin
            cmd_op_d = fifo_rdata;
            csum_d   = fifo_rdata;
            state_d  = S_LEN;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_OP;
          end
        end
      end
      S_LEN: begin
        if (byte_vld_q) begin
          byte_take = 1'b1;
          if (fifo_rdata > MAX_LEN_B) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_LEN;
            state_d     = S_OP;
          end else begin
            cmd_len_d = fifo_rdata;
            rem_d     = fifo_rdata;
            csum_d    = csum_q ^ fifo_rdata;
            state_d   = S_CMD;
          end
        end
      end
      S_CMD: begin
        tmo_d = '0;
        if (cmd_ready) begin
          state_d = (cmd_len_q == 8'd0) ? S_CSUM : S_PAY;
        end
      end
      S_PAY: begin
        if (byte_vld_q && pay_ready) begin
          byte_take = 1'b1;
          csum_d    = csum_q ^ fifo_rdata;
          rem_d     = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (byte_vld_q) begin
          byte_take = 1'b1;
          state_d   = S_OP;
          if (fifo_rdata == csum_q) begin
            frm_done_d = 1'b1;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
      end
      default: state_d = S_OP;
    endcase

    // Only an empty holding register counts as idle; a downstream stall does not.
    if (byte_take) begin
      tmo_d = '0;
    end else if (tmo_active && !byte_vld_q) begin
      if (tmo_q == TMO_LAST) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = S_OP;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // run_q keeps the FIFO untouched until the first clock after reset release.
    fifo_re     = run_q && !fifo_empty && (!byte_vld_q || byte_take);
    byte_vld_d  = fifo_re ? 1'b1 : (byte_take ? 1'b0 : byte_vld_q);
    cmd_valid_d = (state_d == S_CMD);
    busy_d      = (state_d != S_OP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OP;
      byte_vld_q  <= 1'b0;
      run_q       <= 1'b0;
      cmd_op_q    <= '0;
      cmd_len_q   <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      frm_done_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_vld_q  <= byte_vld_d;
      run_q       <= 1'b1;
      cmd_op_q    <= cmd_op_d;
      cmd_len_q   <= cmd_len_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      frm_done_q  <= frm_done_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_len   = cmd_len_q;
  assign pay_valid = (state_q == S_PAY) && byte_vld_q;
  assign pay_data  = fifo_rdata;
  assign pay_last  = (state_q == S_PAY) && (rem_q == 8'd1);
  assign frm_done  = frm_done_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
